// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - registered ALU with iterative RV32M multiply/divide, valid/ready on both sides
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             overflow
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q;
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] p_q;      // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   b_q;      // mul: multiplicand magnitude; div: divisor magnitude
  logic               negq_q;   // negate product / quotient at the end
  logic               negr_q;   // negate remainder at the end
  logic [1:0]         fn_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   res_q;
  logic               ovf_q;

  logic accept;
  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign overflow  = ovf_q;
  assign zero      = (res_q == '0);

  // Base integer ops and add/sub overflow
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic [SHW-1:0]   shamt;
  logic             alu_ovf;
  always_comb begin
    sum     = A + B;
    diff    = A - B;
    shamt   = B[SHW-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op[3:0])
      4'b0000: alu_res = A & B;
      4'b0001: alu_res = A | B;
      4'b0010: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0110: begin
        alu_res = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b1001: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      4'b1100: alu_res = A ^ B;
      4'b1101: alu_res = A >> shamt;
      4'b1110: alu_res = A << shamt;
      4'b1111: alu_res = $unsigned($signed(A) >>> shamt);
      default: alu_res = {{(WIDTH-1){1'b0}}, 1'b1};
    endcase
  end

  // M-op operand signs, magnitudes and the divide corner cases resolved up front
  logic             is_div, sgn_a, sgn_b, b_zero, div_ovf, spec;
  logic [WIDTH-1:0] mag_a, mag_b, spec_res;
  always_comb begin
    is_div = op[2];
    if (is_div) begin
      sgn_a = !op[0] && A[WIDTH-1];
      sgn_b = !op[0] && B[WIDTH-1];
    end else begin
      // mul low half is sign-agnostic, so it runs unsigned
      sgn_a = ((op[1:0] == 2'b01) || (op[1:0] == 2'b10)) && A[WIDTH-1];
      sgn_b = (op[1:0] == 2'b01) && B[WIDTH-1];
    end
    mag_a    = sgn_a ? (~A + 1'b1) : A;
    mag_b    = sgn_b ? (~B + 1'b1) : B;
    b_zero   = (B == '0);
    div_ovf  = !op[0] && (A == MIN_VAL) && (B == '1);
    spec     = is_div && (b_zero || div_ovf);
    if (b_zero) spec_res = op[1] ? A : '1;
    else        spec_res = op[1] ? '0 : MIN_VAL;
  end

  // One shift-add or restoring-subtract step, plus sign fix-up of the final step
  logic [WIDTH:0]     add_w, div_t, div_dt;
  logic [2*WIDTH-1:0] p_d, prod;
  logic [WIDTH-1:0]   q_mag, r_mag, fin_res;
  always_comb begin
    add_w  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
    div_t  = p_q[2*WIDTH-1:WIDTH-1];
    div_dt = div_t - {1'b0, b_q};
    if (state_q == S_DIV) begin
      if (div_dt[WIDTH]) p_d = {div_t[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
      else               p_d = {div_dt[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    end else begin
      p_d = {add_w, p_q[WIDTH-1:1]};
    end
    prod  = negq_q ? (~p_d + 1'b1) : p_d;
    q_mag = p_d[WIDTH-1:0];
    r_mag = p_d[2*WIDTH-1:WIDTH];
    if (state_q == S_MUL)
      fin_res = (fn_q == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    else if (fn_q[1])
      fin_res = negr_q ? (~r_mag + 1'b1) : r_mag;
    else
      fin_res = negq_q ? (~q_mag + 1'b1) : q_mag;
  end

  // Control FSM with registered result, flags and iterative datapath state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      b_q         <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      fn_q        <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (!op[4]) begin
              res_q       <= alu_res;
              ovf_q       <= alu_ovf;
              out_valid_q <= 1'b1;
            end else if (spec) begin
              res_q       <= spec_res;
              ovf_q       <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              out_valid_q <= 1'b0;
              cnt_q       <= '0;
              fn_q        <= op[1:0];
              negq_q      <= sgn_a ^ sgn_b;
              negr_q      <= sgn_a;
              if (is_div) begin
                state_q <= S_DIV;
                p_q     <= {{WIDTH{1'b0}}, mag_a};
                b_q     <= mag_b;
              end else begin
                state_q <= S_MUL;
                p_q     <= {{WIDTH{1'b0}}, mag_b};
                b_q     <= mag_a;
              end
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        S_MUL, S_DIV: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH-1)) begin
            res_q       <= fin_res;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - scoreboard bench for alu_mdu with directed vectors
module tb_alu_mdu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res;
  logic        zero;
  logic        overflow;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       nm;
    logic [31:0] r;
    logic        o;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t hd;
  int   tests = 0;
  int   fails = 0;
  bit   seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic issue(input string nm, input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r, input logic ov,
                       input int lat, input bit push);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk); #1;
    while (!in_ready && n < 200) begin
      in_valid = 1'b0;
      @(negedge clk); #1;
      n++;
    end
    if (!in_ready) chk({nm, "_accept_timeout"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op = o;
    A = a;
    B = b;
    if (push) begin
      e.nm = nm; e.r = r; e.o = ov; e.lat = lat; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: latency on first sight, stability while stalled, full compare on transfer
  initial begin
    forever begin
      @(negedge clk); #2;
      if (rst_n && out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          hd = sb[0];
          if (!seen) begin
            seen = 1'b1;
            chk({hd.nm, "_latency"}, cyc - hd.acc, hd.lat);
          end
          if (out_ready) begin
            chk({hd.nm, "_res"}, res, hd.r);
            chk({hd.nm, "_ovf"}, {31'b0, overflow}, {31'b0, hd.o});
            chk({hd.nm, "_zero"}, {31'b0, zero}, {31'b0, (hd.r == 32'd0)});
            void'(sb.pop_front());
            seen = 1'b0;
          end else begin
            chk({hd.nm, "_stall_res"}, res, hd.r);
            chk({hd.nm, "_stall_in_ready"}, {31'b0, in_ready}, 32'd0);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_res", res, 32'd0);
    chk("reset_zero", {31'b0, zero}, 32'd1);
    chk("reset_ovf", {31'b0, overflow}, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

    // Reset in the middle of a multiply: nothing may come out
    issue("mul_rst", 5'b10000, 32'd3, 32'd5, 32'd15, 1'b0, 33, 1'b0);
    idle();
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_res", res, 32'd0);
    chk("midrst_zero", {31'b0, zero}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (40) @(negedge clk);

    // Back-to-back base ops
    issue("add_ovf", 5'b00010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1, 1'b1);
    issue("sub_ovf", 5'b00110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1, 1'b1);
    issue("sra",     5'b01111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1, 1'b1);
    issue("slt",     5'b00111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1, 1'b1);
    idle();

    // Multiplies
    issue("mulh", 5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33, 1'b1);
    idle();
    chk("mulh_busy", {31'b0, in_ready}, 32'd0);
    repeat (32) begin
      @(negedge clk); #1;
      chk("mulh_busy", {31'b0, in_ready}, 32'd0);
    end
    issue("mulhu", 5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, 1'b1);
    issue("mul",   5'b10000, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 1'b0, 33, 1'b1);

    // Divides
    issue("div",  5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, 1'b1);
    issue("rem",  5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 1'b1);
    issue("divu", 5'b10101, 32'd100, 32'd7, 32'd14, 1'b0, 33, 1'b1);
    issue("remu", 5'b10111, 32'd100, 32'd7, 32'd2, 1'b0, 33, 1'b1);

    // Divide corner cases, single cycle
    issue("div_by0",  5'b10100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 1'b1);
    issue("rem_by0",  5'b10110, 32'd5, 32'd0, 32'd5, 1'b0, 1, 1'b1);
    issue("div_sovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 1'b1);
    issue("rem_sovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1, 1'b1);
    idle();

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end

    // Backpressure on a long op
    out_ready = 1'b0;
    issue("divu_bp", 5'b10101, 32'd100, 32'd7, 32'd14, 1'b0, 33, 1'b1);
    idle();
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("bp_result_present", {31'b0, out_valid}, 32'd1);
    repeat (5) begin
      @(negedge clk); #1;
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_res_stable", res, 32'd14);
    end
    out_ready = 1'b1;
    issue("undef", 5'b01010, 32'h1234_5678, 32'h9ABC_DEF0, 32'd1, 1'b0, 1, 1'b1);
    idle();

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain", sb.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
